ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100_000_000, system clock frequency.
REQ-002 SHALL have parameter INHIBIT_US, default 100, host clock-inhibit duration in microseconds.
REQ-003 SHALL have parameter TIMEOUT_MS, default 15, transaction watchdog limit in milliseconds.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 clrn  input  1  reset, asynchronous, active-low.
REQ-006 tx_valid  input  1  command byte offered.
REQ-007 tx_data  input  8  command byte, e.g. 0xED set-LEDs or 0xFF reset.
REQ-008 tx_ready  output  1  high only in IDLE; the byte is accepted when tx_valid and tx_ready are both high on a clk edge.
REQ-009 ps2_clk_i, ps2_data_i  input  1 each  raw PS/2 line levels, asynchronous.
REQ-010 ps2_clk_oe, ps2_data_oe  output  1 each  open-drain enables; 1 drives the line low, 0 releases it.
REQ-011 busy  output  1  high in every state except IDLE; the PS2 receiver shall ignore the lines while busy is high.
REQ-012 done  output  1  one-cycle pulse when a transaction ends, for success or any error.
REQ-013 ack_err  output  1  qualified by done; device did not pull data low in the ack slot.
REQ-014 timeout_err  output  1  qualified by done; watchdog expired.

Function
REQ-015 ps2_clk_i and ps2_data_i SHALL pass through 2-FF synchronizers; a falling edge is synchronized clock 1 in the previous cycle and 0 now.
REQ-016 States SHALL be IDLE, INHIBIT, REQ, BITS, ACK, WAIT_IDLE.
REQ-017 On accept, the block SHALL latch frame[9:0] = {1'b1 stop, ~^tx_data odd parity, tx_data} and enter INHIBIT on the next cycle.
REQ-018 INHIBIT SHALL assert ps2_clk_oe for exactly N = CLK_FREQ_HZ/1_000_000*INHIBIT_US cycles.
REQ-019 At the end of INHIBIT, the block SHALL enter REQ, asserting ps2_data_oe (start bit 0) for one cycle with ps2_clk_oe still 1; ps2_clk_oe SHALL then drop to 0 and the block enters BITS.
REQ-020 In BITS, on falling edges 1..10 the block SHALL set ps2_data_oe = ~frame[k-1], k = 1..10, LSB first; edge 10 releases data (stop bit).
REQ-021 After edge 10, the block SHALL enter ACK; on the next falling edge, sampled ps2_data_i = 0 means success and 1 sets ack_err.
REQ-022 WAIT_IDLE SHALL hold until the synchronized clock and data are both 1, then pulse done and return to IDLE.
REQ-023 tx_valid while busy SHALL be ignored; no queueing.
REQ-024 ack_err and timeout_err SHALL hold their value from done until the next accept, which clears them.
REQ-025 Both oe outputs SHALL be 0 in IDLE, ACK and WAIT_IDLE.

Reset
REQ-026 With clrn low: state = IDLE, ps2_clk_oe = 0, ps2_data_oe = 0, busy = 0, done = 0, ack_err = 0, timeout_err = 0, all counters 0, tx_ready = 1 after release.
REQ-027 Reset mid-frame SHALL release both lines immediately and asynchronously, with no done pulse.

Configuration
REQ-028 With PS2_HOST_TX_TIMEOUT_EN defined, a watchdog SHALL start at the end of REQ, count TIMEOUT_MS*CLK_FREQ_HZ/1000 cycles and restart on each falling edge.
REQ-029 On watchdog expiry, the block SHALL release both lines, set timeout_err, pulse done and return to IDLE.
REQ-030 Without PS2_HOST_TX_TIMEOUT_EN, there SHALL be no watchdog logic; timeout_err is tied to 0 and BITS/ACK wait indefinitely.

Structure
REQ-031 Package ps2_pkg SHALL hold the ps2_tx_state_t enum, frame length 10, and the command constants CMD_SET_LED = 8'hED, CMD_RESET = 8'hFF, CMD_ACK = 8'hFA.
REQ-032 Synchronizer and falling-edge detect SHALL be one sub-module, ps2_line_sync, instantiated for each line.

Verification
REQ-033 Send 0xED with a device model ACKing. Required: clock held low for 10000 cycles at 100 MHz; bits 1,0,1,1,0,1,1,1; parity 1; stop 1; done pulse with ack_err = 0.
REQ-034 Send 0xF4. Required: parity 0 and data bits 0,0,1,0,1,1,1,1 sampled by the model on rising edges.
REQ-035 Model leaves data high in the ack slot. Required: done with ack_err = 1, lines released.
REQ-036 Model stops clocking after edge 4 (TIMEOUT_EN defined). Required: timeout_err = 1 and done after 1_500_000 cycles; without the macro, busy stays 1.
REQ-037 Assert clrn low during BITS. Required: oe outputs 0 in the same cycle, no done, and a later 0xFF transaction completes normally.
REQ-038 tx_valid with 0x55 while busy. Required: ignored, and the frame in flight is unchanged.

Source files
------------

// File: rtl/ps2_pkg.sv
// ============================================================================
// Module  : ps2_pkg
// Brief   : Shared types and constants for the PS/2 host transmitter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_REQ       = 3'd2,
        S_BITS      = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5
    } ps2_tx_state_t;

    localparam int unsigned c_frame_len = 10;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ACK     = 8'hFA;

    // Frame is shifted LSB first: 8 data bits, odd parity, stop.
    function automatic logic [c_frame_len-1:0] ps2_build_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_line_sync.sv
// ============================================================================
// Module  : ps2_line_sync
// Brief   : Two-flop synchronizer for one raw PS/2 line plus falling-edge detect.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_line_sync (
    input  logic clk,
    input  logic clrn,
    input  logic i_line,
    output logic o_level,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Idle PS/2 lines are high, so reset to 1 to avoid a spurious edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_line;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_fall  = r_prev & ~r_sync;

endmodule

`default_nettype wire

// File: rtl/ps2_host_tx.sv
// ============================================================================
// Module  : ps2_host_tx
// Brief   : PS/2 host-to-device command transmitter (inhibit, request, 8O1 frame,
//           ack check). Optional watchdog enabled by PS2_HOST_TX_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned INHIBIT_US  = 100,
    parameter int unsigned TIMEOUT_MS  = 15
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);

    localparam int unsigned c_inhibit_cycles = CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
    localparam int          c_inh_w   = (c_inhibit_cycles > 1) ? $clog2(c_inhibit_cycles) : 1;
    localparam logic [c_inh_w-1:0] c_inh_last = c_inh_w'(c_inhibit_cycles - 1);
    localparam logic [3:0]  c_last_bit = 4'(c_frame_len - 1);

    ps2_tx_state_t            r_state;
    ps2_tx_state_t            w_state_nxt;
    logic [c_frame_len-1:0]   r_frame;
    logic [c_inh_w-1:0]       r_inh_cnt;
    logic [3:0]               r_bit_cnt;
    logic                     r_data_oe;
    logic                     r_done;
    logic                     r_ack_err;

    logic w_clk_lvl;
    logic w_clk_fall;
    logic w_data_lvl;
    logic w_data_fall;
    logic w_unused_data_fall;
    logic w_accept;
    logic w_finish;
    logic w_wd_expire;

    ps2_line_sync u_clk_sync (
        .clk     (clk),
        .clrn    (clrn),
        .i_line  (ps2_clk_i),
        .o_level (w_clk_lvl),
        .o_fall  (w_clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk     (clk),
        .clrn    (clrn),
        .i_line  (ps2_data_i),
        .o_level (w_data_lvl),
        .o_fall  (w_data_fall)
    );

    assign w_unused_data_fall = w_data_fall;

    assign w_accept = (r_state == S_IDLE) && tx_valid;
    assign w_finish = ((r_state == S_WAIT_IDLE) && w_clk_lvl && w_data_lvl) || w_wd_expire;

    // State register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (tx_valid)                               w_state_nxt = S_INHIBIT;
            S_INHIBIT:   if (r_inh_cnt == c_inh_last)                w_state_nxt = S_REQ;
            S_REQ:                                                   w_state_nxt = S_BITS;
            S_BITS:      if (w_clk_fall && r_bit_cnt == c_last_bit)  w_state_nxt = S_ACK;
            S_ACK:       if (w_clk_fall)                             w_state_nxt = S_WAIT_IDLE;
            S_WAIT_IDLE: if (w_clk_lvl && w_data_lvl)                w_state_nxt = S_IDLE;
            default:                                                 w_state_nxt = S_IDLE;
        endcase
        if (w_wd_expire) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Outputs: lines are only driven while inhibiting, requesting or shifting.
    always_comb begin
        tx_ready    = 1'b0;
        busy        = 1'b1;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        case (r_state)
            S_IDLE: begin
                tx_ready = 1'b1;
                busy     = 1'b0;
            end
            S_INHIBIT: ps2_clk_oe = 1'b1;
            S_REQ: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
            end
            S_BITS:  ps2_data_oe = r_data_oe;
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_frame   <= '0;
            r_inh_cnt <= '0;
            r_bit_cnt <= '0;
            r_data_oe <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
        end else begin
            r_done <= w_finish;
            case (r_state)
                S_IDLE: begin
                    if (tx_valid) begin
                        r_frame   <= ps2_build_frame(tx_data);
                        r_ack_err <= 1'b0;
                        r_inh_cnt <= '0;
                        r_bit_cnt <= '0;
                    end
                end
                S_INHIBIT: begin
                    r_inh_cnt <= (r_inh_cnt == c_inh_last) ? '0 : r_inh_cnt + 1'b1;
                end
                S_REQ: r_data_oe <= 1'b1;
                S_BITS: begin
                    // Drive the complement: oe=1 pulls the line to 0.
                    if (w_clk_fall) begin
                        r_data_oe <= ~r_frame[r_bit_cnt];
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                S_ACK: begin
                    if (w_clk_fall) begin
                        r_ack_err <= w_data_lvl;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done    = r_done;
    assign ack_err = r_ack_err;

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam longint unsigned c_timeout_cycles =
        longint'(TIMEOUT_MS) * longint'(CLK_FREQ_HZ) / 1000;
    localparam int c_wd_w = (c_timeout_cycles > 1) ? $clog2(c_timeout_cycles) : 1;
    localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(c_timeout_cycles - 1);

    logic [c_wd_w-1:0] r_wd_cnt;
    logic              r_timeout_err;
    logic              w_wd_active;

    // Watchdog runs from the end of the request and restarts on every device clock edge.
    assign w_wd_active = (r_state == S_BITS) || (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
    assign w_wd_expire = w_wd_active && (r_wd_cnt == c_wd_last);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (!w_wd_active || w_clk_fall) begin
                r_wd_cnt <= '0;
            end else begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if (w_accept) begin
                r_timeout_err <= 1'b0;
            end else if (w_wd_expire) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    localparam int unsigned c_unused_timeout_ms = TIMEOUT_MS;
    logic w_unused_accept;

    assign w_unused_accept = w_accept;
    assign w_wd_expire     = 1'b0;
    assign timeout_err     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
// ============================================================================
// Module  : tb_ps2_host_tx
// Brief   : Directed bench for ps2_host_tx with a behavioural PS/2 device.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_host_tx;
    import ps2_pkg::*;

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int unsigned CLK_HZ = 2_000_000;
    localparam int unsigned TO_N   = 15 * (CLK_HZ / 1000);
`else
    localparam int unsigned CLK_HZ = 100_000_000;
`endif
    localparam int unsigned INH_N = CLK_HZ / 1_000_000 * 100;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic       ps2_clk_i, ps2_data_i;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       busy, done, ack_err, timeout_err;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    assign ps2_clk_i  = !(ps2_clk_oe  || dev_clk_low);
    assign ps2_data_i = !(ps2_data_oe || dev_data_low);

    ps2_host_tx #(
        .CLK_FREQ_HZ (CLK_HZ),
        .INHIBIT_US  (100),
        .TIMEOUT_MS  (15)
    ) dut (
        .clk         (clk),
        .clrn        (clrn),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .ack_err     (ack_err),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: done pulses and how long the host drives each line pattern.
    int   done_cnt = 0;
    int   inh_cnt  = 0;
    int   req_cnt  = 0;
    logic last_ack = 1'b0;
    logic last_to  = 1'b0;

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            last_ack = ack_err;
            last_to  = timeout_err;
        end
        if (ps2_clk_oe && !ps2_data_oe) inh_cnt++;
        if (ps2_clk_oe && ps2_data_oe)  req_cnt++;
    end

    logic [10:0] dev_bits;
    bit          dev_ok;

    // Device side: bits are read on rising clock edges; stop_after>0 abandons the frame.
    task automatic dev_receive(input bit do_ack, input int stop_after);
        dev_ok   = 1'b0;
        dev_bits = '0;
        for (int i = 0; i < int'(INH_N) + 2000; i++) begin
            @(negedge clk);
            if (ps2_clk_i && !ps2_data_i) begin
                dev_ok = 1'b1;
                break;
            end
        end
        if (!dev_ok) return;
        dev_bits[0] = ps2_data_i;
        for (int k = 1; k <= 10; k++) begin
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            dev_bits[k] = ps2_data_i;
            if (k == stop_after) return;
        end
        repeat (HALF / 2) @(negedge clk);
        if (do_ack) dev_data_low = 1'b1;
        repeat (HALF / 2) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF / 2) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic send(input string tag, input logic [7:0] d);
        @(negedge clk);
        check_eq({tag, "_ready"}, {31'd0, tx_ready}, 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int start);
        for (int i = 0; i < 2000 && done_cnt == start; i++) begin
            @(negedge clk);
            #1;
        end
        repeat (5) @(negedge clk);
        #1;
        check_eq({tag, "_done"}, done_cnt - start, 32'd1);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] d, input logic par);
        check_eq({tag, "_req"},  {31'd0, dev_ok}, 32'd1);
        check_eq({tag, "_data"}, {24'd0, dev_bits[8:1]}, {24'd0, d});
        check_eq({tag, "_par"},  {31'd0, dev_bits[9]}, {31'd0, par});
        check_eq({tag, "_stop"}, {31'd0, dev_bits[10]}, 32'd1);
    endtask

    initial begin
        int start, inh0, req0, cyc;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_busy",   {31'd0, busy},        32'd0);
        check_eq("rst_clk_oe", {31'd0, ps2_clk_oe},  32'd0);
        check_eq("rst_dat_oe", {31'd0, ps2_data_oe}, 32'd0);
        check_eq("rst_done",   {31'd0, done},        32'd0);
        check_eq("rst_errs",   {30'd0, ack_err, timeout_err}, 32'd0);
        clrn = 1'b1;
        @(negedge clk);
        check_eq("rst_ready", {31'd0, tx_ready}, 32'd1);

        // 0xED, acked: inhibit length, request cycle, frame contents
        start = done_cnt; inh0 = inh_cnt; req0 = req_cnt;
        send("ed", CMD_SET_LED);
        dev_receive(1'b1, 0);
        wait_done("ed", start);
        check_frame("ed", 8'hED, 1'b1);
        check_eq("ed_inhibit", inh_cnt - inh0, INH_N);
        check_eq("ed_reqcyc",  req_cnt - req0, 32'd1);
        check_eq("ed_ack_err", {31'd0, last_ack}, 32'd0);
        check_eq("ed_idle",    {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);

        // 0xF4 with 0x55 offered mid-frame
        start = done_cnt;
        send("f4", 8'hF4);
        fork
            dev_receive(1'b1, 0);
            begin
                repeat (INH_N + 100) @(negedge clk);
                check_eq("inj_ready", {31'd0, tx_ready}, 32'd0);
                check_eq("inj_busy",  {31'd0, busy},     32'd1);
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                repeat (3) @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        wait_done("f4", start);
        check_frame("f4", 8'hF4, 1'b0);
        check_eq("f4_ack_err", {31'd0, last_ack}, 32'd0);
        repeat (50) @(negedge clk);
        check_eq("f4_no_extra", done_cnt - start, 32'd1);

        // No ack from device
        start = done_cnt;
        send("nak", 8'h00);
        dev_receive(1'b0, 0);
        wait_done("nak", start);
        check_frame("nak", 8'h00, 1'b1);
        check_eq("nak_ack_err", {31'd0, last_ack}, 32'd1);
        check_eq("nak_idle",    {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        repeat (20) @(negedge clk);
        check_eq("nak_hold", {31'd0, ack_err}, 32'd1);

        // Device stops clocking after edge 4
        start = done_cnt;
        send("to", 8'h3C);
        @(negedge clk);
        check_eq("to_clear_ack", {31'd0, ack_err}, 32'd0);
        dev_receive(1'b1, 4);
`ifdef PS2_HOST_TX_TIMEOUT_EN
        cyc = 0;
        while (done_cnt == start && cyc < int'(TO_N) + 200) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check_eq("to_done",    done_cnt - start, 32'd1);
        check_eq("to_err",     {31'd0, last_to}, 32'd1);
        check_eq("to_latency", {31'd0, (cyc >= int'(TO_N) - HALF - 20) && (cyc <= int'(TO_N))}, 32'd1);
        check_eq("to_idle",    {29'd0, busy, ps2_clk_oe, ps2_data_oe}, 32'd0);
`else
        cyc = 3000;
        repeat (cyc) @(negedge clk);
        check_eq("to_stuck_busy", {31'd0, busy}, 32'd1);
        check_eq("to_no_done",    done_cnt - start, 32'd0);
        check_eq("to_err_zero",   {31'd0, timeout_err}, 32'd0);
`endif
        clrn = 1'b0;
        repeat (2) @(negedge clk);
        clrn = 1'b1;

        // Reset during BITS while data is pulled low
        start = done_cnt;
        send("mid", 8'hA5);
        dev_receive(1'b1, 2);
        repeat (5) @(negedge clk);
        check_eq("mid_pre_oe", {31'd0, ps2_data_oe}, 32'd1);
        #2;
        clrn = 1'b0;
        #1;
        check_eq("mid_rst_oe",   {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        repeat (5) @(negedge clk);
        clrn = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("mid_no_done", done_cnt - start, 32'd0);

        // Normal transaction afterwards
        start = done_cnt;
        send("ff", CMD_RESET);
        dev_receive(1'b1, 0);
        wait_done("ff", start);
        check_frame("ff", 8'hFF, 1'b1);
        check_eq("ff_ack_err", {31'd0, last_ack}, 32'd0);
        check_eq("ff_to_err",  {31'd0, last_to},  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
